// File: rtl/config_chain_master_if.sv
// Shared word-width constant and the data_clk/data_in link between chain segments.
package fp;
    localparam int WORD_LENGTH = 16;
endpackage

interface config_if #(
    parameter int WIDTH = fp::WORD_LENGTH
);
    logic             data_clk;
    logic [WIDTH-1:0] data_in;

    modport master (output data_clk, output data_in);
    modport slave  (input  data_clk, input  data_in);
endinterface

// File: rtl/config_chain_master.sv
// Buffers one frame of config words from a valid/ready host port and shifts it into the
// synapse daisy chain on a divided data_clk; host is held off (wr_ready=0) while full or busy.
module config_chain_master #(
    parameter int WORD_WIDTH = fp::WORD_LENGTH,
    parameter int CHAIN_LEN  = 4,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err,
    output logic                  rd_valid,
    output logic [WORD_WIDTH-1:0] rd_data,
    config_if.master              cfg_out,
    config_if.slave               cfg_ret
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int IW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] FULL     = CW'(CHAIN_LEN);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, FINISH} state_t;

    state_t                state, state_nxt;
    logic [DW-1:0]         div, div_nxt;
    logic [CW-1:0]         idx, idx_nxt, idx_inc;
    logic [CW-1:0]         count, count_nxt;
    logic [WORD_WIDTH-1:0] frame_buf [CHAIN_LEN];
    logic                  data_clk_q, data_clk_nxt;
    logic [WORD_WIDTH-1:0] data_in_q, data_in_nxt;
    logic                  busy_nxt, done_nxt, err_nxt, rd_valid_nxt, wr_ready_nxt;
    logic [WORD_WIDTH-1:0] rd_data_nxt;
    logic                  wr_en, last_phase;

    assign cfg_out.data_clk = data_clk_q;
    assign cfg_out.data_in  = data_in_q;
    assign idx_inc          = idx + 1'b1;
    assign last_phase       = (div == DIV_LAST);

    // All outputs are computed from next-state values so they can be registered.
    always_comb begin
        state_nxt    = state;
        div_nxt      = div;
        idx_nxt      = idx;
        count_nxt    = count;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        rd_valid_nxt = 1'b0;
        rd_data_nxt  = rd_data;
        data_clk_nxt = 1'b0;
        data_in_nxt  = data_in_q;
        wr_en        = 1'b0;
        case (state)
            IDLE: begin
                wr_en = wr_valid && wr_ready;
                if (wr_en) count_nxt = count + 1'b1;
                if (start) begin
                    if (count == FULL) begin
                        state_nxt   = SHIFT_LO;
                        busy_nxt    = 1'b1;
                        idx_nxt     = '0;
                        div_nxt     = '0;
                        data_in_nxt = frame_buf[0];
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SHIFT_LO: begin
                err_nxt = start;
                if (last_phase) begin
                    // Sample the tail before the coming rising edge shifts it out.
                    rd_data_nxt  = cfg_ret.data_in;
                    rd_valid_nxt = 1'b1;
                    state_nxt    = SHIFT_HI;
                    div_nxt      = '0;
                    data_clk_nxt = 1'b1;
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            SHIFT_HI: begin
                err_nxt = start;
                if (last_phase) begin
                    div_nxt = '0;
                    idx_nxt = idx_inc;
                    if (idx_inc == FULL) begin
                        state_nxt = FINISH;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        count_nxt = '0;
                    end else begin
                        state_nxt   = SHIFT_LO;
                        data_in_nxt = frame_buf[idx_inc[IW-1:0]];
                    end
                end else begin
                    div_nxt      = div + 1'b1;
                    data_clk_nxt = 1'b1;
                end
            end
            FINISH: begin
                err_nxt   = start;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        wr_ready_nxt = (state_nxt == IDLE) && (count_nxt < FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            div        <= '0;
            idx        <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_err  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            data_clk_q <= 1'b0;
            data_in_q  <= '0;
            wr_ready   <= 1'b0;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            idx        <= idx_nxt;
            count      <= count_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            start_err  <= err_nxt;
            rd_valid   <= rd_valid_nxt;
            rd_data    <= rd_data_nxt;
            data_clk_q <= data_clk_nxt;
            data_in_q  <= data_in_nxt;
            wr_ready   <= wr_ready_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) frame_buf[count[IW-1:0]] <= wr_data;
    end
endmodule

// File: tb/tb_config_chain_master.sv
// Directed bench: two configurations (CLK_DIV=2/LEN=4 and CLK_DIV=1/LEN=8) driving chain models.
module tb_config_chain_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- DUT A: CLK_DIV=2, CHAIN_LEN=4 ----------------
    logic a_reset = 1'b0, a_wr_valid = 1'b0, a_start = 1'b0;
    logic [15:0] a_wr_data = '0;
    logic a_wr_ready, a_busy, a_done, a_start_err, a_rd_valid;
    logic [15:0] a_rd_data;
    config_if #(.WIDTH(16)) a_cfg_out ();
    config_if #(.WIDTH(16)) a_cfg_ret ();

    config_chain_master #(.WORD_WIDTH(16), .CHAIN_LEN(4), .CLK_DIV(2)) u_a (
        .clk(clk), .reset(a_reset), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
        .wr_data(a_wr_data), .start(a_start), .busy(a_busy), .done(a_done),
        .start_err(a_start_err), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .cfg_out(a_cfg_out), .cfg_ret(a_cfg_ret)
    );

    logic [15:0] a_chain [4];
    int a_rises = 0, a_busy_cnt = 0, a_done_cnt = 0;
    time a_rise_t [$];
    logic [15:0] a_rdq [$];
    assign a_cfg_ret.data_in  = a_chain[3];
    assign a_cfg_ret.data_clk = 1'b0;

    initial for (int i = 0; i < 4; i++) a_chain[i] = '0;
    always @(posedge a_cfg_out.data_clk) begin
        for (int i = 3; i > 0; i--) a_chain[i] <= a_chain[i-1];
        a_chain[0] <= a_cfg_out.data_in;
        a_rises++;
        a_rise_t.push_back($time);
    end
    always @(negedge clk) begin
        if (a_busy) a_busy_cnt++;
        if (a_done) a_done_cnt++;
        if (a_rd_valid) a_rdq.push_back(a_rd_data);
    end

    // ---------------- DUT B: CLK_DIV=1, CHAIN_LEN=8 ----------------
    logic b_reset = 1'b0, b_wr_valid = 1'b0, b_start = 1'b0;
    logic [15:0] b_wr_data = '0;
    logic b_wr_ready, b_busy, b_done, b_start_err, b_rd_valid;
    logic [15:0] b_rd_data;
    config_if #(.WIDTH(16)) b_cfg_out ();
    config_if #(.WIDTH(16)) b_cfg_ret ();

    config_chain_master #(.WORD_WIDTH(16), .CHAIN_LEN(8), .CLK_DIV(1)) u_b (
        .clk(clk), .reset(b_reset), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .wr_data(b_wr_data), .start(b_start), .busy(b_busy), .done(b_done),
        .start_err(b_start_err), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .cfg_out(b_cfg_out), .cfg_ret(b_cfg_ret)
    );

    logic [15:0] b_chain [8];
    int b_rises = 0, b_busy_cnt = 0, b_err_cnt = 0;
    time b_rise_t [$];
    assign b_cfg_ret.data_in  = b_chain[7];
    assign b_cfg_ret.data_clk = 1'b0;

    initial for (int i = 0; i < 8; i++) b_chain[i] = '0;
    always @(posedge b_cfg_out.data_clk) begin
        for (int i = 7; i > 0; i--) b_chain[i] <= b_chain[i-1];
        b_chain[0] <= b_cfg_out.data_in;
        b_rises++;
        b_rise_t.push_back($time);
    end
    always @(negedge clk) begin
        if (b_busy) b_busy_cnt++;
        if (b_start_err) b_err_cnt++;
    end

    // ---------------- helpers (called at a negedge, return at a negedge) ----------------
    task automatic a_write(input logic [15:0] w);
        int n = 0;
        a_wr_valid = 1'b1;
        a_wr_data  = w;
        while (!a_wr_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("a_write_ready", a_wr_ready, 1);
        @(negedge clk);
        a_wr_valid = 1'b0;
    endtask

    task automatic b_write(input logic [15:0] w);
        int n = 0;
        b_wr_valid = 1'b1;
        b_wr_data  = w;
        while (!b_wr_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("b_write_ready", b_wr_ready, 1);
        @(negedge clk);
        b_wr_valid = 1'b0;
    endtask

    task automatic a_start_pulse();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic a_wait_done();
        int n = 0;
        while (!a_done && n < 300) begin @(negedge clk); n++; end
        chk("a_done_seen", a_done, 1);
    endtask

    task automatic a_chain_chk(input string name, input logic [15:0] h0, h1, h2, h3);
        chk({name, "_s0"}, a_chain[0], h0);
        chk({name, "_s1"}, a_chain[1], h1);
        chk({name, "_s2"}, a_chain[2], h2);
        chk({name, "_s3"}, a_chain[3], h3);
    endtask

    // Per-cycle expectations for frame 1, cycle 0 = first cycle after start is accepted.
    typedef struct {
        int          cyc;
        logic        dclk;
        logic [15:0] din;
        logic        chk_din;
        logic        busy;
        logic        done;
        logic        rdv;
    } vec_t;
    vec_t tab [11];

    initial begin
        int base, dbase, bbase, n;
        logic [15:0] exp_rd [4];

        tab[0]  = '{0,  1'b0, 16'h0A01, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[1]  = '{1,  1'b0, 16'h0A01, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[2]  = '{2,  1'b1, 16'h0A01, 1'b1, 1'b1, 1'b0, 1'b1};
        tab[3]  = '{3,  1'b1, 16'h0A01, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[4]  = '{4,  1'b0, 16'h0B02, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[5]  = '{7,  1'b1, 16'h0B02, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[6]  = '{8,  1'b0, 16'h0C03, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[7]  = '{13, 1'b0, 16'h0D04, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[8]  = '{15, 1'b1, 16'h0D04, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[9]  = '{16, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[10] = '{17, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held 5 cycles with a word offered: nothing may be accepted.
        a_wr_valid = 1'b1;
        a_wr_data  = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_dclk", a_cfg_out.data_clk, 0);
            chk("rst_busy", a_busy, 0);
            chk("rst_wr_ready", a_wr_ready, 0);
        end
        chk("rst_done", a_done, 0);
        chk("rst_rd_data", a_rd_data, 0);
        a_reset = 1'b1;
        b_reset = 1'b1;
        @(negedge clk);
        chk("rel_wr_ready", a_wr_ready, 1);
        a_wr_valid = 1'b0;

        // Frame 1
        a_write(16'h0A01); a_write(16'h0B02); a_write(16'h0C03); a_write(16'h0D04);
        chk("full_wr_ready", a_wr_ready, 0);
        base = a_rises; dbase = a_done_cnt; bbase = a_busy_cnt;
        a_rdq.delete();
        a_start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            for (int i = 0; i < 11; i++) begin
                if (tab[i].cyc == c) begin
                    chk($sformatf("f1_dclk_c%0d", c), a_cfg_out.data_clk, tab[i].dclk);
                    if (tab[i].chk_din) chk($sformatf("f1_din_c%0d", c), a_cfg_out.data_in, tab[i].din);
                    chk($sformatf("f1_busy_c%0d", c), a_busy, tab[i].busy);
                    chk($sformatf("f1_done_c%0d", c), a_done, tab[i].done);
                    chk($sformatf("f1_rdv_c%0d", c), a_rd_valid, tab[i].rdv);
                end
            end
        end
        chk("f1_wr_ready_after", a_wr_ready, 1);
        chk("f1_rises", a_rises - base, 4);
        chk("f1_busy_cycles", a_busy_cnt - bbase, 16);
        chk("f1_done_pulses", a_done_cnt - dbase, 1);
        for (int i = base + 1; i < a_rise_t.size(); i++)
            chk("f1_period", 32'(a_rise_t[i] - a_rise_t[i-1]), 40);
        a_chain_chk("f1_chain", 16'h0D04, 16'h0C03, 16'h0B02, 16'h0A01);
        chk("f1_rd_count", a_rdq.size(), 4);

        // Frame 2: readback returns frame 1, tail word first
        a_write(16'h1111); a_write(16'h2222); a_write(16'h3333); a_write(16'h4444);
        a_rdq.delete();
        a_start_pulse();
        a_wait_done();
        @(negedge clk);
        exp_rd[0] = 16'h0A01; exp_rd[1] = 16'h0B02; exp_rd[2] = 16'h0C03; exp_rd[3] = 16'h0D04;
        chk("f2_rd_count", a_rdq.size(), 4);
        for (int i = 0; i < 4 && i < a_rdq.size(); i++)
            chk($sformatf("f2_rd%0d", i), a_rdq[i], exp_rd[i]);
        a_chain_chk("f2_chain", 16'h4444, 16'h3333, 16'h2222, 16'h1111);

        // Partial frame: start rejected, then completed
        a_write(16'h5555); a_write(16'h6666); a_write(16'h7777);
        base = a_rises;
        a_start_pulse();
        chk("part_start_err", a_start_err, 1);
        chk("part_busy", a_busy, 0);
        @(negedge clk);
        chk("part_err_cleared", a_start_err, 0);
        repeat (8) @(negedge clk);
        chk("part_no_edge", a_rises - base, 0);
        a_write(16'h8888);
        a_start_pulse();
        a_wait_done();
        chk("part_rises", a_rises - base, 4);
        a_chain_chk("part_chain", 16'h8888, 16'h7777, 16'h6666, 16'h5555);
        @(negedge clk);

        // Abort after the second rising edge
        a_write(16'h9001); a_write(16'h9002); a_write(16'h9003); a_write(16'h9004);
        base = a_rises; dbase = a_done_cnt;
        a_start_pulse();
        n = 0;
        while (a_rises < base + 2 && n < 100) begin @(negedge clk); n++; end
        chk("abort_two_edges", a_rises - base, 2);
        a_reset = 1'b0;
        @(negedge clk);
        chk("abort_dclk", a_cfg_out.data_clk, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        a_reset = 1'b1;
        @(negedge clk);
        chk("abort_wr_ready", a_wr_ready, 1);
        repeat (20) @(negedge clk);
        chk("abort_edges_final", a_rises - base, 2);
        chk("abort_no_done", a_done_cnt - dbase, 0);
        a_chain_chk("abort_chain", 16'h9002, 16'h9001, 16'h8888, 16'h7777);

        // DUT B: CLK_DIV=1, CHAIN_LEN=8, start held high through done
        for (int i = 0; i < 8; i++) b_write(16'hB000 + 16'(i));
        chk("b_full_wr_ready", b_wr_ready, 0);
        base = b_rises; bbase = b_busy_cnt;
        b_start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_done && n < 100) begin @(negedge clk); n++; end
        chk("b_done_seen", b_done, 1);
        chk("b_busy_at_done", b_busy, 0);
        chk("b_err_at_done", b_start_err, 1);
        chk("b_rises", b_rises - base, 8);
        chk("b_busy_cycles", b_busy_cnt - bbase, 16);
        for (int i = base + 1; i < b_rise_t.size(); i++)
            chk("b_period", 32'(b_rise_t[i] - b_rise_t[i-1]), 20);
        b_err_cnt = 0;
        repeat (3) @(negedge clk);
        chk("b_err_after_done", b_err_cnt, 3);
        chk("b_no_restart", b_busy, 0);
        chk("b_rises_after", b_rises - base, 8);
        b_start = 1'b0;
        chk("b_chain_head", b_chain[0], 16'hB007);
        chk("b_chain_mid", b_chain[4], 16'hB003);
        chk("b_chain_tail", b_chain[7], 16'hB000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
